vga_frame_ring: RTL

Parametrised N-buffer framebuffer (double or triple buffered) between the CPU memory stage and the VGA scan-out. CPU pixel writes always land in the back buffer, and scan-out always reads the front buffer. A CPU swap request is deferred to the next vertical-blank start, so scan-out never tears. In triple-buffer mode a free buffer is handed to the CPU immediately (mailbox policy), and the block exposes a memory-mapped status word.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_frame.sv | 27 ++
 rtl/vga_swap_ctrl.sv | 102 ++++++++++
 rtl/vga_frame_ring.sv | 119 +++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types, bus addresses and status-word layout for the VGA framebuffer ring.
package vga_pkg;

  localparam int unsigned COLOR_W   = 12;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned DROP_W    = 8;
  localparam int unsigned PIX_AW    = 16;
  localparam int unsigned ST_FCNT_W = 16;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } vga_color_t;

  typedef struct packed {
    logic memRead;
    logic memWrite;
  } mem_ctrl_t;

  localparam logic [31:0] VGA_SWAP_ADDR   = 32'h1003_0000;
  localparam logic [31:0] VGA_STATUS_ADDR = 32'h1003_0004;

  // Status word bit positions
  localparam int unsigned ST_F_LSB    = 0;
  localparam int unsigned ST_B_LSB    = 2;
  localparam int unsigned ST_R_LSB    = 4;
  localparam int unsigned ST_RV_BIT   = 6;
  localparam int unsigned ST_P_BIT    = 7;
  localparam int unsigned ST_DROP_LSB = 8;
  localparam int unsigned ST_FCNT_LSB = 16;

endpackage

// File: rtl/vga_frame.sv
// One 256x256 frame: CPU writes on i_clk, scan-out reads on i_vga_clk with one-cycle latency.
module vga_frame
  import vga_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_vga_clk,
  input  logic              i_we,
  input  logic [PIX_AW-1:0] i_addr,
  input  vga_color_t        i_data,
  input  logic [7:0]        i_pxlX,
  input  logic [7:0]        i_pxlY,
  output vga_color_t        o_color
);

  localparam int unsigned DEPTH = 1 << PIX_AW;

  vga_color_t mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr] <= i_data;
  end

  always_ff @(posedge i_vga_clk) begin
    o_color <= mem[{i_pxlY, i_pxlX}];
  end

endmodule

// File: rtl/vga_swap_ctrl.sv
// vblank synchroniser/edge detect and the front/back/ready index machine with its counters.
module vga_swap_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned NUM_BUFFERS = 3,
  parameter int unsigned FCNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_vblank,
  input  logic              i_swap_req,
  output logic [IDX_W-1:0]  o_front,
  output logic [IDX_W-1:0]  o_back,
  output logic [IDX_W-1:0]  o_ready,
  output logic              o_ready_valid,
  output logic              o_pending,
  output logic [DROP_W-1:0] o_drop_cnt,
  output logic [FCNT_W-1:0] o_frame_cnt,
  output logic              o_stall
);

  localparam logic [IDX_W-1:0] R_RST = (NUM_BUFFERS == 3) ? IDX_W'(2) : IDX_W'(0);

  logic vb_s1, vb_s2, vb_s3, pulse;
  logic [IDX_W-1:0]  f_q, b_q, r_q, f_n, b_n, r_n;
  logic              rv_q, rv_n, p_q, p_n;
  logic [DROP_W-1:0] drop_q, drop_n;
  logic [FCNT_W-1:0] fcnt_q, fcnt_n;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      {vb_s1, vb_s2, vb_s3, pulse} <= '0;
    end else begin
      vb_s1 <= i_vblank;
      vb_s2 <= vb_s1;
      vb_s3 <= vb_s2;
      pulse <= vb_s2 & ~vb_s3;
    end
  end

  // The vblank pulse is applied first, then a same-cycle request sees the updated state.
  always_comb begin
    f_n    = f_q;
    b_n    = b_q;
    r_n    = r_q;
    rv_n   = rv_q;
    p_n    = p_q;
    drop_n = drop_q;
    fcnt_n = fcnt_q;
    if (pulse) fcnt_n = fcnt_q + FCNT_W'(1);
    if (NUM_BUFFERS == 2) begin
      if (pulse && p_q) begin
        f_n = b_q;
        b_n = f_q;
        p_n = 1'b0;
      end
      if (i_swap_req && !p_n) p_n = 1'b1;
    end else begin
      if (pulse && rv_q) begin
        f_n  = r_q;
        r_n  = f_q;
        rv_n = 1'b0;
      end
      if (i_swap_req) begin
        if (rv_n && (drop_q != '1)) drop_n = drop_q + DROP_W'(1);
        b_n  = r_n;
        r_n  = b_q;
        rv_n = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      f_q    <= IDX_W'(0);
      b_q    <= IDX_W'(1);
      r_q    <= R_RST;
      rv_q   <= 1'b0;
      p_q    <= 1'b0;
      drop_q <= '0;
      fcnt_q <= '0;
    end else begin
      f_q    <= f_n;
      b_q    <= b_n;
      r_q    <= r_n;
      rv_q   <= rv_n;
      p_q    <= p_n;
      drop_q <= drop_n;
      fcnt_q <= fcnt_n;
    end
  end

  assign o_front       = f_q;
  assign o_back        = b_q;
  assign o_ready       = r_q;
  assign o_ready_valid = rv_q;
  assign o_pending     = p_q;
  assign o_drop_cnt    = drop_q;
  assign o_frame_cnt   = fcnt_q;
  assign o_stall       = p_q;

endmodule

// File: rtl/vga_frame_ring.sv
// N-buffer framebuffer: CPU writes land in the back buffer, scan-out shows the front buffer,
// and swaps are deferred to vertical blank so the picture never tears.
module vga_frame_ring
  import vga_pkg::*;
#(
  parameter int unsigned NUM_BUFFERS = 3,
  parameter logic [31:0] SWAP_ADDR   = VGA_SWAP_ADDR,
  parameter logic [31:0] STATUS_ADDR = VGA_STATUS_ADDR,
  parameter int unsigned FCNT_W      = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_vga_clk,
  input  logic        i_vblank,
  input  logic        en_MEM,
  input  logic [31:0] i_pxlAddr,
  input  logic [31:0] i_pxlData,
  input  mem_ctrl_t   i_ctrlVGA,
  input  logic [7:0]  i_pxlX,
  input  logic [7:0]  i_pxlY,
  output vga_color_t  o_color,
  output logic [31:0] o_readData,
  output logic        o_stall,
  output logic [1:0]  o_frontIdx,
  output logic [1:0]  o_backIdx
);

  if (NUM_BUFFERS != 2 && NUM_BUFFERS != 3) begin : g_bad_cfg
    $error("vga_frame_ring: NUM_BUFFERS must be 2 or 3");
  end

  logic [IDX_W-1:0]  front, back, ready;
  logic              ready_valid, pending, stall;
  logic [DROP_W-1:0] drop_cnt;
  logic [FCNT_W-1:0] frame_cnt;
  logic              bus_wr, swap_req, stat_rd, pix_wr;

  assign bus_wr   = en_MEM & i_ctrlVGA.memWrite;
  assign swap_req = bus_wr & (i_pxlAddr == SWAP_ADDR);
  assign stat_rd  = en_MEM & i_ctrlVGA.memRead & (i_pxlAddr == STATUS_ADDR);
  assign pix_wr   = bus_wr & (i_pxlAddr != SWAP_ADDR) & (i_pxlAddr != STATUS_ADDR) & ~stall;

  vga_swap_ctrl #(
    .NUM_BUFFERS (NUM_BUFFERS),
    .FCNT_W      (FCNT_W)
  ) u_swap_ctrl (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_vblank      (i_vblank),
    .i_swap_req    (swap_req),
    .o_front       (front),
    .o_back        (back),
    .o_ready       (ready),
    .o_ready_valid (ready_valid),
    .o_pending     (pending),
    .o_drop_cnt    (drop_cnt),
    .o_frame_cnt   (frame_cnt),
    .o_stall       (stall)
  );

  logic [PIX_AW-1:0]      pix_addr;
  vga_color_t             pix_data;
  logic                   unused_data_bits;
  logic [NUM_BUFFERS-1:0] frame_we;
  vga_color_t             frame_color [NUM_BUFFERS];

  assign pix_addr         = i_pxlAddr[PIX_AW+1:2];
  assign pix_data         = vga_color_t'(i_pxlData[COLOR_W-1:0]);
  assign unused_data_bits = ^i_pxlData[31:COLOR_W];

  // Only the back buffer ever sees a write strobe.
  always_comb begin
    frame_we = '0;
    for (int i = 0; i < NUM_BUFFERS; i++) frame_we[i] = pix_wr & (back == IDX_W'(i));
  end

  for (genvar gi = 0; gi < NUM_BUFFERS; gi++) begin : g_frame
    vga_frame u_frame (
      .i_clk     (i_clk),
      .i_vga_clk (i_vga_clk),
      .i_we      (frame_we[gi]),
      .i_addr    (pix_addr),
      .i_data    (pix_data),
      .i_pxlX    (i_pxlX),
      .i_pxlY    (i_pxlY),
      .o_color   (frame_color[gi])
    );
  end

  always_comb begin
    o_color = '0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (front == IDX_W'(i)) o_color = frame_color[i];
    end
  end

  logic [31:0] status;

  always_comb begin
    status = '0;
    status[ST_F_LSB +: IDX_W]       = front;
    status[ST_B_LSB +: IDX_W]       = back;
    status[ST_R_LSB +: IDX_W]       = ready;
    status[ST_RV_BIT]               = ready_valid;
    status[ST_P_BIT]                = pending;
    status[ST_DROP_LSB +: DROP_W]   = drop_cnt;
    status[ST_FCNT_LSB +: ST_FCNT_W] = ST_FCNT_W'(frame_cnt);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)   o_readData <= '0;
    else if (stat_rd) o_readData <= status;
  end

  assign o_stall    = stall;
  assign o_frontIdx = front;
  assign o_backIdx  = back;

endmodule
